// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall control for the D->E boundary: data, mult/div and eret-EPC
// interlocks, the mult/div busy counter and a stall-cycle counter.
module hazard_stall_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic [4:0]  D_A1,
   input  logic [4:0]  D_A2,
   input  logic [1:0]  D_tuse_rs,
   input  logic [1:0]  D_tuse_rt,
   input  logic        D_is_md,
   input  logic        D_is_eret,
   input  logic        E_regWrite,
   input  logic [4:0]  E_A3,
   input  logic [1:0]  E_tnew,
   input  logic        E_md_start,
   input  logic        E_md_div,
   input  logic        E_mtc0_epc,
   input  logic        M_regWrite,
   input  logic [4:0]  M_A3,
   input  logic [1:0]  M_tnew,
   input  logic        M_mtc0_epc,
   output logic        en_F,
   output logic        en_D,
   output logic        freeze_E,
   output logic        md_busy,
   output logic [31:0] stall_cnt
);

   localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   logic [CW-1:0] md_cnt_q, md_cnt_d;
   logic [31:0]   stall_cnt_q, stall_cnt_d;
   logic          hz_rs, hz_rt, hz_md, hz_eret, stall;

   always_comb begin
      hz_rs = (D_A1 != 5'd0) &&
              ((E_regWrite && (E_A3 == D_A1) && (E_tnew > D_tuse_rs)) ||
               (M_regWrite && (M_A3 == D_A1) && (M_tnew > D_tuse_rs)));
      hz_rt = (D_A2 != 5'd0) &&
              ((E_regWrite && (E_A3 == D_A2) && (E_tnew > D_tuse_rt)) ||
               (M_regWrite && (M_A3 == D_A2) && (M_tnew > D_tuse_rt)));
      hz_md   = D_is_md && (md_busy || E_md_start);
      hz_eret = D_is_eret && (E_mtc0_epc || M_mtc0_epc);
      stall   = hz_rs || hz_rt || hz_md || hz_eret;
   end

   // An exception flushes everything, so it must never be held off by a stall.
   always_comb begin
      freeze_E  = stall && !Req;
      en_D      = !stall || Req;
      en_F      = !stall || Req;
      md_busy   = (md_cnt_q != '0);
      stall_cnt = stall_cnt_q;
   end

   always_comb begin
      md_cnt_d = md_cnt_q;
      if (E_md_start && !Req)
         md_cnt_d = E_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      else if (md_cnt_q != '0)
         md_cnt_d = md_cnt_q - CW'(1);
      stall_cnt_d = stall_cnt_q + {31'd0, freeze_E};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         md_cnt_q    <= md_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with hand-computed expectations.
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        Req;
   logic [4:0]  D_A1, D_A2, E_A3, M_A3;
   logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
   logic        D_is_md, D_is_eret;
   logic        E_regWrite, E_md_start, E_md_div, E_mtc0_epc;
   logic        M_regWrite, M_mtc0_epc;
   logic        en_F, en_D, freeze_E, md_busy;
   logic [31:0] stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .Req(Req),
      .D_A1(D_A1), .D_A2(D_A2), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
      .D_is_md(D_is_md), .D_is_eret(D_is_eret),
      .E_regWrite(E_regWrite), .E_A3(E_A3), .E_tnew(E_tnew),
      .E_md_start(E_md_start), .E_md_div(E_md_div), .E_mtc0_epc(E_mtc0_epc),
      .M_regWrite(M_regWrite), .M_A3(M_A3), .M_tnew(M_tnew),
      .M_mtc0_epc(M_mtc0_epc),
      .en_F(en_F), .en_D(en_D), .freeze_E(freeze_E),
      .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_stall(input string tag, input logic s);
      chk({tag, "_frz"}, {31'd0, freeze_E}, {31'd0, s});
      chk({tag, "_enF"}, {31'd0, en_F}, {31'd0, ~s});
      chk({tag, "_enD"}, {31'd0, en_D}, {31'd0, ~s});
   endtask

   task automatic clear_in;
      Req = 0; D_A1 = 0; D_A2 = 0; D_tuse_rs = 3; D_tuse_rt = 3;
      D_is_md = 0; D_is_eret = 0;
      E_regWrite = 0; E_A3 = 0; E_tnew = 0;
      E_md_start = 0; E_md_div = 0; E_mtc0_epc = 0;
      M_regWrite = 0; M_A3 = 0; M_tnew = 0; M_mtc0_epc = 0;
   endtask

   initial begin
      int n;
      clear_in();
      reset = 1;
      tick(); tick();
      chk("rst_cnt", stall_cnt, 32'd0);
      chk("rst_busy", {31'd0, md_busy}, 32'd0);
      chk_stall("rst", 1'b0);
      reset = 0;

      // load-use on rs from E
      E_regWrite = 1; E_A3 = 5; E_tnew = 2; D_A1 = 5; D_tuse_rs = 1;
      #1 chk_stall("loaduse", 1'b1);
      tick();
      chk("loaduse_cnt", stall_cnt, 32'd1);

      E_tnew = 1;
      #1 chk_stall("fwd", 1'b0);
      tick();
      chk("fwd_cnt", stall_cnt, 32'd1);

      E_A3 = 0; D_A1 = 0; E_tnew = 2; D_tuse_rs = 0;
      #1 chk_stall("r0", 1'b0);
      tick();

      // rt hazard from M
      clear_in();
      M_regWrite = 1; M_A3 = 7; M_tnew = 1; D_A2 = 7; D_tuse_rt = 0;
      #1 chk_stall("rt_m", 1'b1);
      tick();
      chk("rt_m_cnt", stall_cnt, 32'd2);
      clear_in();

      // mult: issue cycle stalls D_is_md, then 5 busy cycles
      E_md_start = 1; E_md_div = 0; D_is_md = 1;
      #1 chk_stall("mul_issue", 1'b1);
      chk("mul_issue_busy", {31'd0, md_busy}, 32'd0);
      tick();
      E_md_start = 0;
      for (int i = 0; i < 5; i++) begin
         #1 chk("mul_busy", {31'd0, md_busy}, 32'd1);
         chk("mul_frz", {31'd0, freeze_E}, 32'd1);
         tick();
      end
      #1 chk("mul_done", {31'd0, md_busy}, 32'd0);
      chk_stall("mul_md_idle", 1'b0);
      chk("mul_cnt", stall_cnt, 32'd8);
      D_is_md = 0;

      // div start suppressed by Req
      E_md_start = 1; E_md_div = 1; Req = 1; D_is_md = 1;
      #1 chk_stall("div_req", 1'b0);
      tick();
      clear_in();
      #1 chk("div_req_busy", {31'd0, md_busy}, 32'd0);
      chk("div_req_cnt", stall_cnt, 32'd8);

      // div: 10 busy cycles; Req during the count does not abort it
      E_md_start = 1; E_md_div = 1;
      tick();
      clear_in();
      n = 0;
      for (int i = 0; i < 20; i++) begin
         Req = (i == 0);
         #1 if (md_busy) n++;
         tick();
      end
      Req = 0;
      chk("div_len", n, 32'd10);

      // eret vs mtc0 EPC in E then M
      D_is_eret = 1; E_mtc0_epc = 1;
      #1 chk_stall("eret_e", 1'b1);
      tick();
      E_mtc0_epc = 0; M_mtc0_epc = 1;
      #1 chk_stall("eret_m", 1'b1);
      tick();
      M_mtc0_epc = 0;
      #1 chk_stall("eret_rel", 1'b0);
      chk("eret_cnt", stall_cnt, 32'd10);
      clear_in();

      // Req overrides a hazard
      E_regWrite = 1; E_A3 = 9; E_tnew = 2; D_A1 = 9; D_tuse_rs = 0; Req = 1;
      #1 chk_stall("req_prio", 1'b0);
      tick();
      chk("req_prio_cnt", stall_cnt, 32'd10);
      clear_in();

      // reset mid-div
      E_md_start = 1; E_md_div = 1;
      tick();
      clear_in();
      tick(); tick();
      chk("pre_rst_busy", {31'd0, md_busy}, 32'd1);
      reset = 1;
      tick();
      reset = 0;
      chk("rst_mid_busy", {31'd0, md_busy}, 32'd0);
      chk("rst_mid_cnt", stall_cnt, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
